// File: rtl/output_vector_packer.sv
// ---------------------------------------------------------------------------
// output_vector_packer
//
// Producer side of the final-layer argmax interface. Serial neuron values are
// gathered into a packed frame of numOutput slots. The frame is presented with
// a single-cycle valid pulse. The upstream stream is then held off until the
// argmax stage reports completion, because that stage restarts its scan if a
// new valid arrives part-way through.
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   i_data           serial neuron value
//   i_valid          i_data valid this cycle
//   o_ready          packer accepts i_data (transfer = i_valid & o_ready)
//   o_data           packed frame; slot k at [k*dataWidth +: dataWidth]
//   o_data_valid     one-cycle pulse, o_data holds a complete frame
//   i_consumer_done  pulse from the argmax stage, result is ready
//   o_drop_count     saturating count of i_valid cycles while not collecting
// ---------------------------------------------------------------------------
module output_vector_packer #(
  parameter int numOutput = 10,
  parameter int dataWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [dataWidth-1:0]           i_data,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic [numOutput*dataWidth-1:0] o_data,
  output logic                           o_data_valid,
  input  logic                           i_consumer_done,
  output logic [7:0]                     o_drop_count
);

  // A single-slot frame still needs a one-bit counter to exist.
  localparam int CNT_W = (numOutput > 1) ? $clog2(numOutput) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(numOutput - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT,
    WAIT_DONE
  } state_t;

  state_t                           state;
  state_t                           state_next;
  logic [CNT_W-1:0]                 slot_cnt;
  logic [dataWidth-1:0]             slot_buf [numOutput];
  logic                             xfer;
  logic                             last_xfer;
  logic [numOutput*dataWidth-1:0]   frame;

  // o_ready is registered as (state == COLLECT), so the state itself
  // qualifies the handshake.
  assign xfer      = i_valid && (state == COLLECT);
  assign last_xfer = xfer && (slot_cnt == LAST_SLOT);

  // NOTE: every signal written in a combinational block gets a default
  // first, so no path through the block can leave it unassigned (latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      state_next = COLLECT;
      COLLECT:   if (last_xfer) state_next = EMIT;
      EMIT:      state_next = WAIT_DONE;
      WAIT_DONE: if (i_consumer_done) state_next = COLLECT;
      default:   state_next = IDLE;
    endcase
  end

  // The final word bypasses the buffer so the frame is complete on the
  // same edge that accepts it.
  always_comb begin
    frame = '0;
    for (int k = 0; k < numOutput; k++) begin
      frame[k*dataWidth +: dataWidth] = (k == numOutput - 1) ? i_data : slot_buf[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      slot_cnt     <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_ready      <= 1'b0;
      o_drop_count <= 8'd0;
    end else begin
      state        <= state_next;
      // Outputs follow the next state so they are registered yet aligned
      // with the state they describe.
      o_ready      <= (state_next == COLLECT);
      o_data_valid <= (state_next == EMIT);

      if (last_xfer) begin
        slot_cnt <= '0;
        o_data   <= frame;
      end else if (xfer) begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      if (i_valid && (state != COLLECT) && (o_drop_count != 8'hFF)) begin
        o_drop_count <= o_drop_count + 8'd1;
      end
    end
  end

  // NOTE: the slot buffer is deliberately not reset. A partial frame is
  // discarded on reset and every slot is rewritten before the next copy to
  // o_data, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (xfer) begin
      slot_buf[slot_cnt] <= i_data;
    end
  end

endmodule

// File: tb/tb_output_vector_packer.sv
// ---------------------------------------------------------------------------
// tb_output_vector_packer
//
// Directed bench for output_vector_packer (numOutput=10, dataWidth=16) plus a
// small numOutput=1 instance. Inputs change on the falling edge; outputs are
// sampled on the falling edge, half a period away from the active edge.
// ---------------------------------------------------------------------------
module tb_output_vector_packer;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [VW-1:0] o_data;
  logic          o_data_valid;
  logic          i_consumer_done = 1'b0;
  logic [7:0]    o_drop_count;

  logic [W-1:0]  i_data1 = '0;
  logic          i_valid1 = 1'b0;
  logic          o_ready1;
  logic [W-1:0]  o_data1;
  logic          o_data_valid1;
  logic          i_consumer_done1 = 1'b0;
  logic [7:0]    o_drop_count1;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;

  always #5 clk = ~clk;

  output_vector_packer #(.numOutput(N), .dataWidth(W)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_data          (i_data),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .o_data          (o_data),
    .o_data_valid    (o_data_valid),
    .i_consumer_done (i_consumer_done),
    .o_drop_count    (o_drop_count)
  );

  output_vector_packer #(.numOutput(1), .dataWidth(W)) u_dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_data          (i_data1),
    .i_valid         (i_valid1),
    .o_ready         (o_ready1),
    .o_data          (o_data1),
    .o_data_valid    (o_data_valid1),
    .i_consumer_done (i_consumer_done1),
    .o_drop_count    (o_drop_count1)
  );

  // Counts valid pulses of the main instance using pre-edge values.
  always @(posedge clk) if (o_data_valid) valid_cnt++;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic push(input logic [W-1:0] d);
    int n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", VW'(o_ready), VW'(1));
    i_valid = 1'b1;
    i_data  = d;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_data",  o_data, '0);
    check("rst_valid", VW'(o_data_valid), '0);
    check("rst_ready", VW'(o_ready), '0);
    check("rst_drop",  VW'(o_drop_count), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", VW'(o_ready), VW'(1));
  endtask

  task automatic done_pulse();
    i_consumer_done = 1'b1;
    @(negedge clk);
    i_consumer_done = 1'b0;
    check("ready_after_done", VW'(o_ready), VW'(1));
  endtask

  function automatic int argmax(input logic [VW-1:0] v);
    int best = 0;
    for (int k = 1; k < N; k++)
      if (v[k*W +: W] > v[best*W +: W]) best = k;
    return best;
  endfunction

  logic [W-1:0]  vals [N];
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] held;
  int            vc0;
  logic          ready_seen;

  initial begin
    do_reset();

    // Single-slot instance: every accepted word is its own frame.
    check("n1_ready", VW'(o_ready1), VW'(1));
    i_valid1 = 1'b1;
    i_data1  = 16'h1234;
    @(negedge clk);
    i_valid1 = 1'b0;
    check("n1_valid", VW'(o_data_valid1), VW'(1));
    check("n1_data",  VW'(o_data1), VW'(16'h1234));
    check("n1_ready_low", VW'(o_ready1), '0);
    @(negedge clk);
    i_consumer_done1 = 1'b1;
    @(negedge clk);
    i_consumer_done1 = 1'b0;
    check("n1_ready_again", VW'(o_ready1), VW'(1));

    // Back-to-back frame 0x0001..0x000A.
    for (int k = 0; k < N; k++) vals[k] = W'(k + 1);
    exp_vec = '0;
    for (int k = 0; k < N; k++) exp_vec[k*W +: W] = vals[k];
    vc0 = valid_cnt;
    for (int k = 0; k < N; k++) push(vals[k]);
    check("b2b_ready_drop", VW'(o_ready), '0);
    check("b2b_valid",      VW'(o_data_valid), VW'(1));
    check("b2b_slot0",      VW'(o_data[15:0]), VW'(16'h0001));
    check("b2b_slot9",      VW'(o_data[159:144]), VW'(16'h000A));
    check("b2b_frame",      o_data, exp_vec);
    @(negedge clk);
    check("b2b_valid_one",  VW'(o_data_valid), '0);
    check("b2b_pulses",     VW'(valid_cnt - vc0), VW'(1));

    // Drops while waiting for the consumer.
    held = o_data;
    i_valid = 1'b1;
    i_data  = 16'hBEEF;
    repeat (3) @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    check("drop_3",       VW'(o_drop_count), VW'(3));
    check("drop_data",    o_data, held);
    check("drop_pulses",  VW'(valid_cnt - vc0), VW'(1));
    done_pulse();

    // Same values with random idle gaps.
    vc0 = valid_cnt;
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(vals[k]);
    end
    check("gap_valid", VW'(o_data_valid), VW'(1));
    check("gap_frame", o_data, exp_vec);
    repeat (4) @(negedge clk);
    check("gap_pulses", VW'(valid_cnt - vc0), VW'(1));
    done_pulse();

    // Reset mid-frame after 5 words.
    for (int k = 0; k < 5; k++) push(W'(16'h0011 + k));
    do_reset();
    for (int k = 0; k < N; k++) vals[k] = W'(16'h0101 + k);
    exp_vec = '0;
    for (int k = 0; k < N; k++) exp_vec[k*W +: W] = vals[k];
    for (int k = 0; k < N; k++) push(vals[k]);
    check("post_rst_slot0", VW'(o_data[15:0]), VW'(16'h0101));
    check("post_rst_frame", o_data, exp_vec);
    @(negedge clk);
    done_pulse();

    // Argmax stage: max at slot 6, then slot 2.
    for (int k = 0; k < N; k++) vals[k] = (k == 6) ? 16'h7FFF : W'(k + 3);
    for (int k = 0; k < N; k++) push(vals[k]);
    vc0 = valid_cnt;
    check("argmax_a_valid", VW'(o_data_valid), VW'(1));
    check("argmax_a", VW'(argmax(o_data)), VW'(6));
    // Second frame offered before the done pulse must be held off.
    ready_seen = 1'b0;
    i_valid = 1'b1;
    i_data  = 16'h7FFF;
    repeat (5) begin
      @(negedge clk);
      if (o_ready) ready_seen = 1'b1;
    end
    i_valid = 1'b0;
    check("hold_ready",  VW'(ready_seen), '0);
    check("hold_pulses", VW'(valid_cnt - vc0), VW'(1));
    check("hold_drop",   VW'(o_drop_count), VW'(5));
    done_pulse();
    for (int k = 0; k < N; k++) vals[k] = (k == 2) ? 16'h7FFF : W'(16'h0100 + k);
    for (int k = 0; k < N; k++) push(vals[k]);
    check("argmax_b_valid", VW'(o_data_valid), VW'(1));
    check("argmax_b", VW'(argmax(o_data)), VW'(2));

    // Saturation while stuck in WAIT_DONE.
    @(negedge clk);
    i_valid = 1'b1;
    repeat (300) @(negedge clk);
    i_valid = 1'b0;
    check("drop_sat", VW'(o_drop_count), VW'(255));
    check("sat_ready", VW'(o_ready), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_vector_packer.md
Name: output_vector_packer

Overview:
- Producer side of the final-layer argmax interface.
- Collects a serial stream of per-neuron output values into one packed wide vector of numOutput slots.
- Presents the vector with a single-cycle valid pulse.
- Holds off the upstream stream until the downstream argmax stage signals it has finished that vector, because the argmax stage restarts if a new valid arrives mid-scan.

Parameters:
- numOutput, 10, number of neuron values per frame (number of slots in the packed vector).
- dataWidth, 16, width of each neuron value in bits.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_data  input  dataWidth  serial neuron value.
- i_valid  input  1  i_data is valid this cycle.
- o_ready  output  1  packer accepts i_data this cycle; a word transfers when i_valid and o_ready are both high.
- o_data  output  numOutput*dataWidth  packed frame; slot k is at bits [k*dataWidth +: dataWidth].
- o_data_valid  output  1  one-cycle pulse, o_data holds a complete frame.
- i_consumer_done  input  1  pulse from the argmax stage indicating its result is ready.
- o_drop_count  output  8  saturating count of i_valid cycles that arrive while o_ready is low.

Behaviour:
- Interface requirement: one clock, clk. Reset is asynchronous and active-low on rst_n.
- All outputs and state are registered and clear asynchronously on rst_n low.
- Reset values:
  - o_data = 0
  - o_data_valid = 0
  - o_ready = 0
  - o_drop_count = 0
  - slot counter = 0
  - state = IDLE
- IDLE: o_ready=0. Unconditionally moves to COLLECT on the next clk edge after reset deasserts. o_ready rises with that edge.
- COLLECT: o_ready=1.
  - Each transfer writes i_data into slot[counter] of the internal buffer, then counter increments.
  - Slot 0 holds the first word of the frame.
  - Idle cycles (i_valid low) do not change the counter.
  - When the transfer lands in slot numOutput-1:
    - counter returns to 0.
    - The buffer, including the final word, is copied to o_data.
    - The state moves to EMIT.
    - o_ready drops on the same edge.
  - Only this copy and reset update o_data. Between frames o_data stays stable.
- EMIT: o_data_valid=1 for exactly this one cycle, o_ready=0. Moves to WAIT_DONE unconditionally.
  - Latency: o_data_valid is high in the cycle after the clock edge that accepted the last word.
- WAIT_DONE: o_ready=0, o_data_valid=0.
  - When i_consumer_done is high, move to COLLECT; o_ready is 1 in the next cycle.
  - i_consumer_done is ignored in IDLE, COLLECT and EMIT.
- Drop counting:
  - In any state other than COLLECT, each cycle with i_valid=1 increments o_drop_count.
  - o_drop_count saturates at 255 and clears only on reset.
  - Dropped words never reach the buffer.
- Width rules: values are stored bit-exact, with no sign handling or arithmetic. The slot counter is sized ceil(log2(numOutput)) bits and must never exceed numOutput-1.
- Reset mid-frame discards the partial frame. The first word after reset lands in slot 0.
- numOutput=1 is legal. Every accepted word produces its own frame.

Test Plan:
- Stream 0x0001..0x000A back-to-back from COLLECT (numOutput=10):
  - o_ready drops on the edge that accepts 0x000A.
  - o_data_valid pulses exactly one cycle, in the cycle after 0x000A is accepted.
  - o_data[15:0]=0x0001 and o_data[159:144]=0x000A.
- Same ten values with random 0-3 cycle gaps on i_valid -> identical o_data and a single valid pulse.
- In WAIT_DONE, drive 3 cycles of i_valid with 0xBEEF:
  - o_drop_count=3, o_data unchanged, no extra valid pulse.
  - Then pulse i_consumer_done -> o_ready=1 in the next cycle.
- Assert rst_n low after 5 accepted words:
  - o_data=0, o_data_valid=0, o_ready=0 immediately (asynchronous).
  - o_ready=1 one cycle after deassertion.
  - The next 10 words form a clean frame with word 1 in slot 0.
- Connect to the argmax stage and send two consecutive frames, max 0x7FFF at slot 6 then at slot 2:
  - The stage reports index 6, then index 2.
  - The second frame is not emitted before the first done pulse.
- Hold i_valid high for 300 cycles while stuck in WAIT_DONE (no done pulse) -> o_drop_count saturates at 255.
